// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the pipeline
// sequencing controller, bundled so the core and the controller share one port.
interface pipeline_ctrl_if;
    logic        load_use;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_req;

    logic        en_pc;
    logic        en_if_id;
    logic        en_id_ex;
    logic        en_ex_mem;
    logic        en_mem_wb;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic        mem_error;
    logic [15:0] stall_count;

    // Core side: raises hazards, consumes enables/flushes.
    modport master (
        output load_use, branch_taken, mem_req, mem_ready, halt_req,
        input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        input  flush_if_id, flush_id_ex, halted, mem_error, stall_count
    );

    // Controller side.
    modport slave (
        input  load_use, branch_taken, mem_req, mem_ready, halt_req,
        output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        output flush_if_id, flush_id_ex, halted, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal execution, hazards resolved by stall/flush
// DRAIN  | halt accepted: PC frozen, ID..WB retire, IF/ID bubbled
// HALTED | core stopped (drain done or memory timeout); exit by reset
//
// Enables/flushes are combinational from state and hazard inputs so the
// pipeline freezes in the same cycle a hazard is raised. While reset is
// held low the registers see enable=0 / flush=1 and clear every clock.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);

    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 halt_pending_q, halt_pending_d;
    logic                 mem_error_q, mem_error_d;
    logic [15:0]          stall_count_q, stall_count_d;

    logic mem_stall;
    logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic flush_if_id, flush_id_ex;

    assign mem_stall = bus.mem_req & ~bus.mem_ready;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            halt_pending_q <= 1'b0;
            mem_error_q    <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            halt_pending_q <= halt_pending_d;
            mem_error_q    <= mem_error_d;
            stall_count_q  <= stall_count_d;
        end
    end

    // Hazard priority, pipeline controls and next-state logic.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        halt_pending_d = halt_pending_q;
        mem_error_d    = mem_error_q;
        stall_count_d  = stall_count_q;
        en_pc          = 1'b0;
        en_if_id       = 1'b0;
        en_id_ex       = 1'b0;
        en_ex_mem      = 1'b0;
        en_mem_wb      = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;

        if (!reset) begin
            // Registers clear on every clock while reset is held.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            case (state_q)
                RUN, DRAIN: begin
                    if (mem_stall) begin
                        // Whole pipeline frozen; flushes held off so nothing is lost.
                        if (wait_cnt_q == WAIT_MAX) begin
                            state_d     = HALTED;
                            mem_error_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt_d = '0;
                        en_pc      = 1'b1;
                        en_if_id   = 1'b1;
                        en_id_ex   = 1'b1;
                        en_ex_mem  = 1'b1;
                        en_mem_wb  = 1'b1;
                        if (bus.branch_taken) begin
                            flush_if_id = 1'b1;
                            flush_id_ex = 1'b1;
                        end else if (bus.load_use) begin
                            en_pc       = 1'b0;
                            en_if_id    = 1'b0;
                            flush_id_ex = 1'b1;
                        end
                        if (state_q == DRAIN) begin
                            // No new fetches; IF/ID fed bubbles unless it must hold.
                            en_pc = 1'b0;
                            if (!(bus.load_use && !bus.branch_taken))
                                flush_if_id = 1'b1;
                        end
                    end

                    if (state_q == RUN) begin
                        if (!en_pc && stall_count_q != 16'hFFFF)
                            stall_count_d = stall_count_q + 16'd1;
                        if (mem_stall) begin
                            if (bus.halt_req)
                                halt_pending_d = 1'b1;
                        end else if (bus.halt_req || halt_pending_q) begin
                            state_d        = DRAIN;
                            drain_cnt_d    = '0;
                            halt_pending_d = 1'b0;
                        end
                    end else if (!mem_stall && !bus.load_use) begin
                        if (drain_cnt_q == DRAIN_LAST)
                            state_d = HALTED;
                        else
                            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.en_pc       = en_pc;
    assign bus.en_if_id    = en_if_id;
    assign bus.en_id_ex    = en_id_ex;
    assign bus.en_ex_mem   = en_ex_mem;
    assign bus.en_mem_wb   = en_mem_wb;
    assign bus.flush_if_id = flush_if_id;
    assign bus.flush_id_ex = flush_id_ex;
    assign bus.halted      = (state_q == HALTED);
    assign bus.mem_error   = mem_error_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage ARM core. It drives the enable and flush (synchronous clear) pins of the PC register and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use stalls, taken-branch flushes, data-memory wait states with timeout, and an orderly halt/drain, and keeps a saturating stall counter. Control outputs are combinational from state plus hazard inputs so the pipeline freezes in the same cycle a hazard is flagged.

## Interface
- MEM_TIMEOUT, default 255: consecutive memory-wait cycles tolerated; the (MEM_TIMEOUT+1)-th causes error. Must be ≥1.
- DRAIN_CYCLES, default 4: unstalled cycles needed to retire ID..WB contents after a halt.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_use  in  1  ID instruction sources a register loaded by the EX instruction.
- branch_taken  in  1  EX resolved a taken branch.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- halt_req  in  1  halt request; single-cycle pulse, latched internally.
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  register enables.
- flush_if_id, flush_id_ex  out  1 each  synchronous clear (bubble); flush dominates enable at the register.
- halted  out  1  core stopped.
- mem_error  out  1  sticky memory timeout flag.
- stall_count  out  16  saturating count of cycles with en_pc=0 in RUN.

## Operation
- States: RUN, DRAIN, HALTED. Internal: wait_cnt (counts up to MEM_TIMEOUT), drain_cnt, halt_pending.
- mem_stall = mem_req & ~mem_ready.
- Priority in RUN and DRAIN, highest first:
  - mem_stall: all five enables 0, both flushes 0; wait_cnt increments. If wait_cnt==MEM_TIMEOUT, next state HALTED and mem_error←1.
  - branch_taken: all enables 1, flush_if_id=1, flush_id_ex=1.
  - load_use: en_pc=0, en_if_id=0, flush_if_id=0, flush_id_ex=1, rest enabled.
  - none: all enables 1, flushes 0.
- wait_cnt clears on any cycle without mem_stall.
- RUN, halt_req or halt_pending, and no mem_stall: go to DRAIN, drain_cnt←0, halt_pending←0. halt_req during mem_stall sets halt_pending.
- DRAIN: en_pc=0 always. flush_if_id=1 except on load_use cycles (then 0 with en_if_id=0). drain_cnt increments only on cycles with no mem_stall and no load_use. The cycle drain_cnt reaches DRAIN_CYCLES-1 and increments → next HALTED. branch_taken in DRAIN also flushes ID/EX.
- HALTED: all enables 0, flushes 0, halted=1. Exit only by reset. halt_req ignored.
- stall_count: increments in RUN when en_pc=0, saturates at 16'hFFFF, never wraps.

## Timing
- Reset (reset=0, asynchronous): state RUN. All enables 0, flush_if_id=flush_id_ex=1, so pipeline registers clear on each clock while reset is held. halted=0, mem_error=0, stall_count=0, wait_cnt=drain_cnt=0, halt_pending=0.
- First cycle after reset deassertion: normal RUN outputs.
- Enables and flushes: zero latency, combinational.
- mem_ready returning high releases the freeze in that same cycle. Lower-priority hazards apply that cycle.
- Memory timeout: mem_stall held MEM_TIMEOUT+1 consecutive cycles. mem_error and halted go high after the edge that ends that cycle.
- Halt latency with no hazards: halt_req at cycle 0 → DRAIN cycles 1..DRAIN_CYCLES → halted=1 at cycle DRAIN_CYCLES+1.
- Reset mid-DRAIN or in HALTED: immediate return to reset values.

## Test plan
- Reset: hold reset=0 for 3 clocks → enables all 0, flushes 1, halted=0, stall_count=0. Release → all enables 1, flushes 0.
- Load-use: load_use=1 for one cycle → en_pc=en_if_id=0, flush_id_ex=1 that cycle; stall_count=1. Same cycle with branch_taken=1 → branch wins: both flushes 1, all enables 1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → enables 0 for 3 cycles, 1 on the 4th; stall_count=3; mem_error=0.
- Timeout (MEM_TIMEOUT=4): mem_req=1, mem_ready=0 held → after 5th stalled cycle, mem_error=1, halted=1. mem_ready=1 later → no change until reset.
- Halt with hazard: halt_req pulse during a memory stall, ready 2 cycles later → DRAIN entered after release. One load_use in DRAIN extends the drain by 1 cycle; halted=1 after 4 unstalled drain cycles.
- Saturation: preload via 65 540 load_use cycles → stall_count holds 16'hFFFF.
